chnl_cfg_regs: RTL

Register block that drives the per-slave configuration fields (enable, priority, packet length) toward the arbiter/formatter datapath and captures the per-slave FIFO availability for readback. It decodes a simple command bus (write/read/idle) from the test-bench or host side into the same slv0..slv2 field set that the datapath consumes. It sits between the host command interface and the channel/arbiter/formatter DUT.

---
 rtl/chnl_cfg_regs.sv | 116 +++++++++++
 1 files changed

// File: rtl/chnl_cfg_regs.sv
// Host-visible configuration and status registers for three slave channels.
// CTRLn drive the enable/priority/length fields; STATn track FIFO free space.
module chnl_cfg_regs #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic        RST_EN     = 1'b1,
  parameter logic [1:0]  RST_PRIO   = 2'd3,
  parameter logic [2:0]  RST_LEN    = 3'd0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [1:0]            cmd,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data_i,
  output logic [DATA_WIDTH-1:0] cmd_data_o,
  output logic                  cmd_err,
  input  logic [7:0]            slv0_avail,
  input  logic [7:0]            slv1_avail,
  input  logic [7:0]            slv2_avail,
  output logic                  slv0_en,
  output logic                  slv1_en,
  output logic                  slv2_en,
  output logic [1:0]            slv0_prio,
  output logic [1:0]            slv1_prio,
  output logic [1:0]            slv2_prio,
  output logic [2:0]            slv0_len,
  output logic [2:0]            slv1_len,
  output logic [2:0]            slv2_len
);

  localparam logic [1:0] CmdRd = 2'b01;
  localparam logic [1:0] CmdWr = 2'b10;

  // CTRL layout: {len[2:0], prio[1:0], en}
  localparam logic [5:0] RstCtrl = {RST_LEN, RST_PRIO, RST_EN};

  logic [2:0][5:0]        ctrl_q, ctrl_d;
  logic [2:0][7:0]        stat_q;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic                   is_wr, is_rd;
  logic                   ctrl_hit, stat_hit;
  logic [1:0]             idx;
  logic                   unused_wdata;

  assign unused_wdata = ^cmd_data_i[DATA_WIDTH-1:6];

  always_comb begin
    is_wr    = (cmd == CmdWr);
    is_rd    = (cmd == CmdRd);
    ctrl_hit = 1'b0;
    stat_hit = 1'b0;
    idx      = 2'd0;
    for (int i = 0; i < 3; i++) begin
      if (cmd_addr == ADDR_WIDTH'(4 * i)) begin
        ctrl_hit = 1'b1;
        idx      = 2'(i);
      end
      if (cmd_addr == ADDR_WIDTH'(16 + 4 * i)) begin
        stat_hit = 1'b1;
        idx      = 2'(i);
      end
    end
  end

  always_comb begin
    ctrl_d  = ctrl_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    if (is_wr) begin
      if (ctrl_hit) begin
        ctrl_d[idx] = cmd_data_i[5:0];
      end else begin
        // STAT is read-only; writes to it or unmapped space only flag an error
        err_d = 1'b1;
      end
    end else if (is_rd) begin
      if (ctrl_hit) begin
        rdata_d = DATA_WIDTH'(ctrl_q[idx]);
      end else if (stat_hit) begin
        rdata_d = DATA_WIDTH'(stat_q[idx]);
      end else begin
        rdata_d = '0;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ctrl_q  <= {3{RstCtrl}};
      stat_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      stat_q  <= {slv2_avail, slv1_avail, slv0_avail};
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign cmd_data_o = rdata_q;
  assign cmd_err    = err_q;

  assign slv0_en   = ctrl_q[0][0];
  assign slv1_en   = ctrl_q[1][0];
  assign slv2_en   = ctrl_q[2][0];
  assign slv0_prio = ctrl_q[0][2:1];
  assign slv1_prio = ctrl_q[1][2:1];
  assign slv2_prio = ctrl_q[2][2:1];
  assign slv0_len  = ctrl_q[0][5:3];
  assign slv1_len  = ctrl_q[1][5:3];
  assign slv2_len  = ctrl_q[2][5:3];

endmodule
